// File: rtl/ws2812_rx_decoder.sv
// WS2812 line receiver: classifies high pulses as 0/1 and assembles 24-bit GRB pixels MSB first.
// Strobes (data_dv, frame_done, err) appear three clocks after the qualifying din sample.
module ws2812_rx_decoder #(
   parameter int BIT_THRESH = 30,
   parameter int MIN_HIGH   = 5,
   parameter int MAX_HIGH   = 100,
   parameter int RESET_CLKS = 2500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din,
   output logic [23:0] rgb_data_out,
   output logic        data_dv,
   output logic [15:0] pixel_count,
   output logic        frame_done,
   output logic        err,
   output logic        busy
);

   localparam logic [15:0] THRESH_W     = 16'(BIT_THRESH);
   localparam logic [15:0] MIN_W        = 16'(MIN_HIGH);
   localparam logic [15:0] MAX_W        = 16'(MAX_HIGH);
   localparam logic [15:0] GAP_LAST_W   = 16'(RESET_CLKS - 1);

   typedef enum logic [1:0] {
      WAIT_LATCH,
      IDLE,
      HIGH,
      LOW
   } state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic sync_0, sync_1, line_d;
   logic line, rise, fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_0 <= 1'b0;
         sync_1 <= 1'b0;
         line_d <= 1'b0;
      end else begin
         sync_0 <= din;
         sync_1 <= sync_0;
         line_d <= sync_1;
      end
   end

   assign line = sync_1;
   assign rise = sync_1 & ~line_d;
   assign fall = ~sync_1 & line_d;

   state_t      state, state_n;
   logic [15:0] high_cnt, high_n;
   logic [15:0] low_cnt, low_n;
   logic [4:0]  bit_cnt, bit_n;
   logic [22:0] shift_reg, shift_n;
   logic        ev_dv, ev_fd, ev_err;
   logic        dv_n, fd_n, err_n;
   logic [23:0] ev_word, word_n;
   logic        new_bit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= WAIT_LATCH;
         high_cnt  <= '0;
         low_cnt   <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         ev_dv     <= 1'b0;
         ev_fd     <= 1'b0;
         ev_err    <= 1'b0;
         ev_word   <= '0;
      end else begin
         state     <= state_n;
         high_cnt  <= high_n;
         low_cnt   <= low_n;
         bit_cnt   <= bit_n;
         shift_reg <= shift_n;
         ev_dv     <= dv_n;
         ev_fd     <= fd_n;
         ev_err    <= err_n;
         ev_word   <= word_n;
      end
   end

   always_comb begin
      state_n = state;
      high_n  = high_cnt;
      low_n   = low_cnt;
      bit_n   = bit_cnt;
      shift_n = shift_reg;
      dv_n    = 1'b0;
      fd_n    = 1'b0;
      err_n   = 1'b0;
      word_n  = ev_word;
      new_bit = (high_cnt >= THRESH_W);

      case (state)
         WAIT_LATCH: begin
            if (line) begin
               low_n = '0;
            end else if (low_cnt >= GAP_LAST_W) begin
               low_n   = '0;
               state_n = IDLE;
            end else begin
               low_n = sat_inc(low_cnt);
            end
         end
         IDLE: begin
            if (rise) begin
               high_n  = 16'd1;
               state_n = HIGH;
            end
         end
         HIGH: begin
            // Overlong and glitch pulses both abandon the frame until a fresh latch gap.
            if ((high_cnt > MAX_W) || (fall && (high_cnt < MIN_W))) begin
               err_n   = 1'b1;
               bit_n   = '0;
               shift_n = '0;
               low_n   = '0;
               state_n = WAIT_LATCH;
            end else if (fall) begin
               shift_n = {shift_reg[21:0], new_bit};
               low_n   = 16'd1;
               state_n = LOW;
               if (bit_cnt == 5'd23) begin
                  word_n = {shift_reg, new_bit};
                  dv_n   = 1'b1;
                  bit_n  = '0;
               end else begin
                  bit_n = bit_cnt + 5'd1;
               end
            end else begin
               high_n = sat_inc(high_cnt);
            end
         end
         LOW: begin
            if (rise) begin
               high_n  = 16'd1;
               state_n = HIGH;
            end else if (low_cnt >= GAP_LAST_W) begin
               fd_n    = 1'b1;
               low_n   = '0;
               state_n = IDLE;
               if (bit_cnt != 5'd0) begin
                  err_n   = 1'b1;
                  bit_n   = '0;
                  shift_n = '0;
               end
            end else begin
               low_n = sat_inc(low_cnt);
            end
         end
         default: state_n = WAIT_LATCH;
      endcase
   end

   // Output stage; pixel_count keeps the frame total for the frame_done cycle, then clears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb_data_out <= '0;
         data_dv      <= 1'b0;
         pixel_count  <= '0;
         frame_done   <= 1'b0;
         err          <= 1'b0;
      end else begin
         data_dv    <= ev_dv;
         frame_done <= ev_fd;
         err        <= ev_err;
         if (ev_dv) begin
            rgb_data_out <= ev_word;
            pixel_count  <= sat_inc(pixel_count);
         end else if (frame_done || err) begin
            pixel_count <= '0;
         end
      end
   end

   assign busy = (state == HIGH) || (state == LOW);

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Directed bench for ws2812_rx_decoder: drives WS2812 waveforms and checks decoded pixels and strobes.
module tb_ws2812_rx_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        din;
   logic [23:0] rgb_data_out;
   logic        data_dv;
   logic [15:0] pixel_count;
   logic        frame_done;
   logic        err;
   logic        busy;

   ws2812_rx_decoder dut (
      .clk          (clk),
      .rst          (rst),
      .din          (din),
      .rgb_data_out (rgb_data_out),
      .data_dv      (data_dv),
      .pixel_count  (pixel_count),
      .frame_done   (frame_done),
      .err          (err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Event monitor, sampled on the falling edge.
   logic [23:0] dv_words[$];
   logic [15:0] dv_pcs[$];
   int          fd_cnt, err_cnt, err_fd_cnt, dv_fd_cnt;
   logic [15:0] fd_pc, pc_after_fd;
   logic        fd_prev;

   always @(negedge clk) begin
      if (!rst) begin
         if (data_dv) begin
            dv_words.push_back(rgb_data_out);
            dv_pcs.push_back(pixel_count);
         end
         if (fd_prev) pc_after_fd = pixel_count;
         if (frame_done) begin
            fd_cnt++;
            fd_pc = pixel_count;
            if (err) err_fd_cnt++;
            if (data_dv) dv_fd_cnt++;
         end
         if (err) err_cnt++;
         fd_prev = frame_done;
      end else begin
         fd_prev = 1'b0;
      end
   end

   task automatic clear_mon();
      dv_words.delete();
      dv_pcs.delete();
      fd_cnt      = 0;
      err_cnt     = 0;
      err_fd_cnt  = 0;
      dv_fd_cnt   = 0;
      fd_pc       = 16'hBAD0;
      pc_after_fd = 16'hBAD1;
   endtask

   function automatic logic [31:0] word_at(input int i);
      return (i < dv_words.size()) ? {8'h00, dv_words[i]} : 32'hDEADBEEF;
   endfunction

   function automatic logic [31:0] pc_at(input int i);
      return (i < dv_pcs.size()) ? {16'h0000, dv_pcs[i]} : 32'hDEADBEEF;
   endfunction

   task automatic hold(input logic v, input int n);
      din = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_raw(input int h, input int l);
      hold(1'b1, h);
      hold(1'b0, l);
   endtask

   task automatic send_bit(input logic b);
      if (b) send_raw(40, 22);
      else   send_raw(20, 42);
   endtask

   task automatic send_pixel(input logic [23:0] w);
      for (int i = 23; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_rgb"},   {8'h00, rgb_data_out}, 32'h0);
      check({tag, "_dv"},    {31'h0, data_dv},      32'h0);
      check({tag, "_pc"},    {16'h0, pixel_count},  32'h0);
      check({tag, "_fd"},    {31'h0, frame_done},   32'h0);
      check({tag, "_err"},   {31'h0, err},          32'h0);
      check({tag, "_busy"},  {31'h0, busy},         32'h0);
   endtask

   initial begin
      logic [23:0] w;
      rst = 1'b1;
      din = 1'b0;
      clear_mon();
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      hold(1'b0, 3000);

      // Single pixel with explicit data_dv latency check.
      clear_mon();
      w = 24'hA50FF0;
      for (int i = 23; i >= 1; i--) send_bit(w[i]);
      hold(1'b1, 20);
      check("t1_busy_mid", {31'h0, busy}, 32'h1);
      din = 1'b0;
      repeat (3) @(negedge clk);
      check("t1_dv_early", {31'h0, data_dv}, 32'h0);
      @(negedge clk);
      check("t1_dv_lat3", {31'h0, data_dv}, 32'h1);
      check("t1_rgb_lat3", {8'h0, rgb_data_out}, 32'h00A50FF0);
      hold(1'b0, 2996);
      check("t1_dv_cnt", dv_words.size(), 1);
      check("t1_word", word_at(0), 32'h00A50FF0);
      check("t1_fd_cnt", fd_cnt, 1);
      check("t1_fd_pc", {16'h0, fd_pc}, 32'd1);
      check("t1_pc_after", {16'h0, pc_after_fd}, 32'd0);
      check("t1_err_cnt", err_cnt, 0);
      check("t1_busy_end", {31'h0, busy}, 32'h0);
      check("t1_rgb_hold", {8'h0, rgb_data_out}, 32'h00A50FF0);

      // Three back-to-back pixels.
      clear_mon();
      send_pixel(24'h000001);
      send_pixel(24'hFFFFFF);
      send_pixel(24'h800000);
      hold(1'b0, 2600);
      check("t2_dv_cnt", dv_words.size(), 3);
      check("t2_word0", word_at(0), 32'h00000001);
      check("t2_word1", word_at(1), 32'h00FFFFFF);
      check("t2_word2", word_at(2), 32'h00800000);
      check("t2_pc0", pc_at(0), 32'd1);
      check("t2_pc1", pc_at(1), 32'd2);
      check("t2_pc2", pc_at(2), 32'd3);
      check("t2_fd_cnt", fd_cnt, 1);
      check("t2_fd_pc", {16'h0, fd_pc}, 32'd3);
      check("t2_err_cnt", err_cnt, 0);
      check("t2_dv_fd", dv_fd_cnt, 0);

      // Threshold 29/30 and pulse-width limits 5 and 100.
      clear_mon();
      for (int i = 23; i >= 0; i--) begin
         if (i % 2 == 0) send_raw(30, 32);
         else            send_raw(29, 33);
      end
      for (int i = 23; i >= 0; i--) begin
         if (i == 23 || i == 0) send_raw(100, 22);
         else                   send_raw(5, 57);
      end
      hold(1'b0, 2600);
      check("t3_dv_cnt", dv_words.size(), 2);
      check("t3_word_thresh", word_at(0), 32'h00555555);
      check("t3_word_limits", word_at(1), 32'h00800001);
      check("t3_err_cnt", err_cnt, 0);
      check("t3_fd_pc", {16'h0, fd_pc}, 32'd2);

      // Glitch mid-pixel, then recovery after a latch gap.
      clear_mon();
      w = 24'hFF00FF;
      for (int i = 23; i >= 14; i--) send_bit(w[i]);
      send_raw(3, 40);
      check("t4_busy_after_glitch", {31'h0, busy}, 32'h0);
      for (int i = 13; i >= 0; i--) send_bit(w[i]);
      hold(1'b0, 2600);
      check("t4_err_cnt", err_cnt, 1);
      check("t4_dv_cnt", dv_words.size(), 0);
      check("t4_fd_cnt", fd_cnt, 0);
      clear_mon();
      send_pixel(24'h3C5A96);
      hold(1'b0, 2600);
      check("t4_rec_dv_cnt", dv_words.size(), 1);
      check("t4_rec_word", word_at(0), 32'h003C5A96);
      check("t4_rec_err", err_cnt, 0);

      // Partial pixel at latch, then stuck-high line.
      clear_mon();
      w = 24'hABCDEF;
      for (int i = 23; i >= 12; i--) send_bit(w[i]);
      hold(1'b0, 3000);
      check("t5_err_fd", err_fd_cnt, 1);
      check("t5_err_cnt", err_cnt, 1);
      check("t5_fd_cnt", fd_cnt, 1);
      check("t5_dv_cnt", dv_words.size(), 0);
      clear_mon();
      hold(1'b1, 200);
      check("t5_stuck_err", err_cnt, 1);
      check("t5_stuck_busy", {31'h0, busy}, 32'h0);
      hold(1'b0, 50);
      send_pixel(24'h123456);
      hold(1'b0, 2600);
      check("t5_ignored_dv", dv_words.size(), 0);
      check("t5_ignored_fd", fd_cnt, 0);
      check("t5_ignored_err", err_cnt, 1);

      // Reset during bit 10 of a pixel.
      clear_mon();
      w = 24'h5AA55A;
      for (int i = 23; i >= 14; i--) send_bit(w[i]);
      din = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_outputs_zero("t6_rst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      hold(1'b1, 37);
      hold(1'b0, 22);
      for (int i = 12; i >= 0; i--) send_bit(w[i]);
      hold(1'b0, 2600);
      check("t6_ignored_dv", dv_words.size(), 0);
      check("t6_ignored_fd", fd_cnt, 0);
      check("t6_ignored_err", err_cnt, 0);
      send_pixel(24'hC3A5E1);
      hold(1'b0, 2600);
      check("t6_dv_cnt", dv_words.size(), 1);
      check("t6_word", word_at(0), 32'h00C3A5E1);
      check("t6_fd_pc", {16'h0, fd_pc}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ws2812_rx_decoder.md
Name: ws2812_rx_decoder

Overview:
- Receive-side counterpart of the WS2812 one-wire transmit path.
- Samples a WS2812 serial line, classifies each high pulse as 0 or 1, and assembles 24-bit GRB pixel words, MSB first.
- Detects the reset/latch gap, reports frame completion and protocol errors.
- Used for on-board loopback of the `data` output and as the bench monitor for the transmit interface.

Parameters:
- BIT_THRESH, 30, clocks of high time at or above which a bit decodes as 1 (600 ns at 50 MHz).
- MIN_HIGH, 5, high pulses shorter than this are glitches.
- MAX_HIGH, 100, high time above this is a stuck-high error.
- RESET_CLKS, 2500, low time that constitutes a latch/reset gap (50 us at 50 MHz).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- din  input  1  WS2812 serial line, asynchronous to clk
- rgb_data_out  output  24  last decoded pixel, GRB, bit 23 = first bit received
- data_dv  output  1  one-cycle strobe, rgb_data_out valid
- pixel_count  output  16  pixels completed in current frame
- frame_done  output  1  one-cycle strobe at latch-gap detection
- err  output  1  one-cycle strobe on any protocol error
- busy  output  1  high while a frame is in progress (state HIGH or LOW)

Behaviour:
- Reset values:
  - All outputs 0.
  - State WAIT_LATCH.
  - Shift register, bit counter, high/low counters 0.
- Input conditioning:
  - din passes a 2-FF synchronizer, then a third register for edge detection.
  - All timing is measured on the synchronized signal.
- Counters:
  - high_cnt and low_cnt are 16 bits and saturate at 16'hFFFF.
  - bit_cnt is 5 bits, range 0..23.
- State WAIT_LATCH:
  - Count consecutive low clocks; any high sample clears the count.
  - When low count reaches RESET_CLKS, go to IDLE. No frame_done pulse here.
- State IDLE:
  - On rising edge: high_cnt = 1, go to HIGH.
- State HIGH:
  - high_cnt increments each clock while high.
  - If high_cnt exceeds MAX_HIGH: pulse err, discard partial bits, go to WAIT_LATCH.
  - On falling edge:
    - If high_cnt < MIN_HIGH: pulse err, discard partial bits, go to WAIT_LATCH.
    - Otherwise shift in (high_cnt >= BIT_THRESH), then go to LOW with low_cnt = 1.
    - If this was bit 24: rgb_data_out takes the assembled word, data_dv pulses, pixel_count increments (saturating at 16'hFFFF), bit_cnt returns to 0.
- State LOW:
  - low_cnt increments each clock.
  - Rising edge: high_cnt = 1, go to HIGH.
  - If low_cnt reaches RESET_CLKS:
    - frame_done pulses.
    - If bit_cnt != 0, err pulses in the same cycle and the partial pixel is discarded.
    - Go to IDLE.
- frame_done / pixel_count:
  - pixel_count holds the frame total during the frame_done cycle and clears to 0 on the next cycle.
- Latency:
  - data_dv is high exactly 3 clk rising edges after the clk edge that first samples din low at the end of bit 24.
  - frame_done is high 3 edges after the sampling edge on which the low run reaches RESET_CLKS.
- rgb_data_out holds its value until the next completed pixel; it is never cleared except by rst.
- Simultaneous events: err and frame_done may assert together (partial-pixel latch). data_dv and frame_done never share a cycle.
- Reset mid-frame:
  - rst aborts immediately; all outputs return to 0.
  - The decoder must see a full RESET_CLKS low gap before decoding, so a frame already in progress is ignored entirely.
- busy is 0 in WAIT_LATCH and IDLE, 1 in HIGH and LOW.

Test Plan:
- One pixel 24'hA50FF0, bit period 62 clocks (T1H = 40, T0H = 20), after 3000-clock low lead-in, then 3000 clocks low.
  - data_dv once, rgb_data_out = 24'hA50FF0.
  - frame_done once, with pixel_count = 1 in that cycle and 0 the next.
  - err never.
- Three pixels 24'h000001, 24'hFFFFFF, 24'h800000, back-to-back, then latch.
  - Three data_dv pulses with those values in order.
  - pixel_count 1, 2, 3; frame_done with count 3.
- Threshold boundary: bits with high time 29 and 30 clocks.
  - Decode as 0 and 1 respectively.
  - Pixel of alternating 29/30 highs decodes to 24'h555555.
- 3-clock glitch pulse mid-pixel.
  - err pulses; no data_dv for that pixel.
  - Decoding resumes only after a 2500-clock low gap; the next clean pixel decodes correctly.
- 12 valid bits, then line low for 3000 clocks.
  - err and frame_done in the same cycle; no data_dv.
  - line held high 200 clocks → err, busy falls, subsequent pulses ignored until latch gap.
- Assert rst for 2 clocks at bit 10 of a pixel.
  - All outputs 0 immediately.
  - Rest of that frame ignored; next frame after a latch gap decodes normally.
